// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   INSTR_W_DEFAULT : default instruction word width
//   PC_STEP         : byte distance between sequential instructions
//   fetch_state_e   : fetch controller states
package fetch_stage_pkg;

  localparam int unsigned INSTR_W_DEFAULT = 32;
  localparam int unsigned PC_STEP         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between the fetch controller and decode.
//   clk, rst        : clock, asynchronous active-low reset
//   push, push_data : write one entry (accepted when not full, or full with pop)
//   pop             : remove the head entry (ignored when empty)
//   flush           : synchronous clear; wins over push and pop
//   valid, full     : occupancy flags
//   head            : oldest entry (content undefined when !valid)
module fetch_fifo #(
  parameter int unsigned WIDTH = 97
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    // When full, the slot under wr_ptr is the head being popped this edge.
    do_push = push && ((count != 2'd2) || do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != 2'd0);
  assign full  = (count == 2'd2);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time
// from the PC held in the register file, buffers responses in a 2-entry
// FIFO for decode, and advances or redirects the PC through pc_wr.
//   clk, rst                     : clock, asynchronous active-low reset
//   pc_in                        : current PC (valid the cycle after pc_wr)
//   pc_wr, pc_wr_data            : PC update strobe and value
//   imem_req_valid/ready/addr    : instruction memory request
//   imem_rsp_valid/data/err      : instruction memory response
//   redirect_valid, redirect_pc  : control-flow redirect
//   instr_valid/ready/data/pc/fault : buffered instruction to decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  pc_in,
  output logic               pc_wr,
  output logic [DATA_W-1:0]  pc_wr_data,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [DATA_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               imem_rsp_err,
  input  logic               redirect_valid,
  input  logic [DATA_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [DATA_W-1:0]  instr_pc,
  output logic               instr_fault
);

  localparam int unsigned ENTRY_W = DATA_W + INSTR_W + 1;

  fetch_state_e       state_q, state_d;
  logic               drop_q, drop_d;
  logic [DATA_W-1:0]  req_pc_q, req_pc_d;
  logic               pc_wr_q, pc_wr_d;
  logic [DATA_W-1:0]  pc_wr_data_q, pc_wr_data_d;

  logic               req_fire;
  logic               fifo_push;
  logic               fifo_flush;
  logic               fifo_pop;
  logic               fifo_valid;
  logic               fifo_full;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] push_entry;

  // pc_in is stale while a PC write is being pulsed, so a request waits
  // out that cycle. Decoded only from registered state.
  assign imem_req_valid = (state_q == REQ) && !pc_wr_q && !fifo_full;
  assign imem_req_addr  = imem_req_valid ? pc_in : '0;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign pc_wr      = pc_wr_q;
  assign pc_wr_data = pc_wr_data_q;

  assign push_entry = {req_pc_q, imem_rsp_data, imem_rsp_err};

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    req_pc_d     = req_pc_q;
    pc_wr_d      = 1'b0;
    pc_wr_data_d = pc_wr_data_q;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (req_fire) begin
          req_pc_d = pc_in;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else if (imem_rsp_err) begin
            fifo_push = 1'b1;
            state_d   = HALT;
          end else begin
            fifo_push    = 1'b1;
            pc_wr_d      = 1'b1;
            pc_wr_data_d = req_pc_q + DATA_W'(PC_STEP);
            state_d      = REQ;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    // A redirect overrides everything above. If a request is still in
    // flight afterwards, its response must be swallowed via the drop flag.
    if (redirect_valid && (state_q != IDLE)) begin
      fifo_flush   = 1'b1;
      fifo_push    = 1'b0;
      pc_wr_d      = 1'b1;
      pc_wr_data_d = redirect_pc;
      if (((state_q == WAIT) && !imem_rsp_valid) || ((state_q == REQ) && req_fire)) begin
        state_d = WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = REQ;
        drop_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      drop_q       <= 1'b0;
      req_pc_q     <= '0;
      pc_wr_q      <= 1'b0;
      pc_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      req_pc_q     <= req_pc_d;
      pc_wr_q      <= pc_wr_d;
      pc_wr_data_q <= pc_wr_data_d;
    end
  end

  assign fifo_pop = instr_valid && instr_ready;

  fetch_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .valid    (fifo_valid),
    .full     (fifo_full),
    .head     (fifo_head)
  );

  assign instr_valid = fifo_valid;
  assign instr_pc    = fifo_valid ? fifo_head[ENTRY_W-1 -: DATA_W] : '0;
  assign instr_data  = fifo_valid ? fifo_head[INSTR_W:1] : '0;
  assign instr_fault = fifo_valid ? fifo_head[0] : 1'b0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a transaction-level model of the
// instruction buffer, PC updates and request permission.
module tb_fetch_stage;

  localparam int unsigned DW = 64;
  localparam int unsigned IW = 32;

  logic          clk;
  logic          rst;
  logic [DW-1:0] pc_in;
  logic          pc_wr;
  logic [DW-1:0] pc_wr_data;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [DW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          imem_rsp_err;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr_data;
  logic [DW-1:0] instr_pc;
  logic          instr_fault;

  fetch_stage #(.DATA_W(DW), .INSTR_W(IW)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_wr(pc_wr), .pc_wr_data(pc_wr_data),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_fault(instr_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register-file PC slot: not reset by the fetch stage reset.
  logic [DW-1:0] pc_reg = '0;
  always @(posedge clk) if (pc_wr) pc_reg <= pc_wr_data;
  assign pc_in = pc_reg;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [IW-1:0] data;
    logic          err;
  } ent_t;

  // Model state: what must hold after the most recent clock edge.
  ent_t          m_q[$];
  bit            m_idle, m_halt, m_out, m_drop, m_pcwr;
  logic [DW-1:0] m_pcwr_data, m_out_pc;
  bit            prev_rv, prev_rdy, prev_redir, prev_rst;
  logic [DW-1:0] prev_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   allowed, hs, pop;
    ent_t e;
    if (!rst) begin
      chk("rst_req_valid",  64'(imem_req_valid), 64'd0);
      chk("rst_pc_wr",      64'(pc_wr),          64'd0);
      chk("rst_instr_valid",64'(instr_valid),    64'd0);
      chk("rst_pc_wr_data", pc_wr_data,          64'd0);
      chk("rst_req_addr",   imem_req_addr,       64'd0);
      chk("rst_instr_data", 64'(instr_data),     64'd0);
      chk("rst_instr_pc",   instr_pc,            64'd0);
      chk("rst_instr_fault",64'(instr_fault),    64'd0);
      m_q.delete();
      m_idle = 1; m_halt = 0; m_out = 0; m_drop = 0; m_pcwr = 0; m_pcwr_data = '0;
      prev_rv = 0;
    end else begin
      chk("instr_valid", 64'(instr_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("instr_pc",    instr_pc,          m_q[0].pc);
        chk("instr_data",  64'(instr_data),   64'(m_q[0].data));
        chk("instr_fault", 64'(instr_fault),  64'(m_q[0].err));
      end
      chk("pc_wr", 64'(pc_wr), 64'(m_pcwr));
      if (m_pcwr) chk("pc_wr_data", pc_wr_data, m_pcwr_data);
      allowed = !m_idle && !m_halt && !m_out && (m_q.size() < 2) && !m_pcwr;
      if (imem_req_valid) begin
        chk("req_allowed", 64'(allowed), 64'd1);
        chk("req_addr", imem_req_addr, pc_in);
      end
      if (prev_rv && !prev_rdy && !prev_redir && prev_rst) begin
        chk("req_hold", 64'(imem_req_valid), 64'd1);
        chk("req_hold_addr", imem_req_addr, prev_addr);
      end

      hs  = imem_req_valid && imem_req_ready;
      pop = (m_q.size() != 0) && instr_ready;
      m_pcwr = 0;
      if (m_idle) begin
        m_idle = 0;
      end else if (redirect_valid) begin
        m_q.delete();
        m_halt = 0;
        m_pcwr = 1;
        m_pcwr_data = redirect_pc;
        if ((m_out && !imem_rsp_valid) || hs) begin
          m_out = 1; m_drop = 1;
        end else begin
          m_out = 0; m_drop = 0;
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_out && imem_rsp_valid) begin
          m_out = 0;
          if (m_drop) m_drop = 0;
          else begin
            e.pc = m_out_pc; e.data = imem_rsp_data; e.err = imem_rsp_err;
            m_q.push_back(e);
            if (imem_rsp_err) m_halt = 1;
            else begin
              m_pcwr = 1;
              m_pcwr_data = m_out_pc + 64'd4;
            end
          end
        end else if (hs) begin
          m_out = 1;
          m_out_pc = pc_in;
        end
      end
      prev_rv = imem_req_valid;
    end
    prev_rdy   = imem_req_ready;
    prev_redir = redirect_valid;
    prev_rst   = rst;
    prev_addr  = imem_req_addr;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name, input logic [63:0] exp_addr);
    int unsigned n = 0;
    while (!imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_seen"}, 64'(imem_req_valid), 64'd1);
    if (imem_req_valid) chk(name, imem_req_addr, exp_addr);
  endtask

  task automatic respond(input logic [IW-1:0] data, input logic err);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
  endtask

  task automatic redirect(input logic [DW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0;
    m_idle = 1;
    #2 rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    // First fetch from PC 0.
    wait_req("first_req_addr", 64'h0);
    tick();
    respond(32'h0000_0013, 1'b0);
    chk("t1_pc_wr",       64'(pc_wr), 64'd1);
    chk("t1_pc_wr_data",  pc_wr_data, 64'd4);
    chk("t1_instr_pc",    instr_pc, 64'h0);
    chk("t1_instr_data",  64'(instr_data), 64'h13);
    tick();
    chk("t1_pc_wr_once",  64'(pc_wr), 64'd0);

    // Back-to-back responses with decode stalled fill the buffer.
    wait_req("second_req_addr", 64'h4);
    tick();
    respond(32'h0000_0093, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_third_req", 64'(imem_req_valid), 64'd0);
    end
    chk("full_head_pc", instr_pc, 64'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("after_pop_pc",   instr_pc, 64'h4);
    chk("after_pop_data", 64'(instr_data), 64'h93);
    wait_req("third_req_addr", 64'h8);

    // Redirect while the request is outstanding.
    tick();
    redirect(64'h1000);
    chk("redir_flush",   64'(instr_valid), 64'd0);
    chk("redir_pc_wr",   64'(pc_wr), 64'd1);
    chk("redir_pc_data", pc_wr_data, 64'h1000);
    respond(32'hDEAD_BEEF, 1'b0);
    chk("late_rsp_no_push", 64'(instr_valid), 64'd0);
    chk("late_rsp_no_pcwr", 64'(pc_wr), 64'd0);
    imem_req_ready = 1'b0;
    wait_req("redir_req_addr", 64'h1000);

    // Faulting fetch at 0x8 halts until redirect.
    redirect(64'h8);
    imem_req_ready = 1'b1;
    wait_req("err_req_addr", 64'h8);
    tick();
    respond(32'h0BAD_0001, 1'b1);
    chk("err_fault", 64'(instr_fault), 64'd1);
    chk("err_pc",    instr_pc, 64'h8);
    chk("err_no_pcwr", 64'(pc_wr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_no_req", 64'(imem_req_valid), 64'd0);
    end
    imem_req_ready = 1'b0;
    redirect(64'h20);
    chk("halt_redir_flush", 64'(instr_valid), 64'd0);
    chk("halt_redir_data",  pc_wr_data, 64'h20);
    wait_req("halt_redir_req", 64'h20);

    // PC wrap at the top of the address space.
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready = 1'b1;
    wait_req("wrap_req_addr", 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    respond(32'h0000_0013, 1'b0);
    chk("wrap_pc_wr",   64'(pc_wr), 64'd1);
    chk("wrap_pc_data", pc_wr_data, 64'h0);
    chk("wrap_instr_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Reset during WAIT; stale response after release is ignored.
    imem_req_ready = 1'b0;
    redirect(64'h400);
    imem_req_ready = 1'b1;
    wait_req("pre_rst_req", 64'h400);
    tick();
    rst = 1'b0;
    tick();
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    respond(32'h0000_0BAD, 1'b0);
    chk("stale_rsp_no_push", 64'(instr_valid), 64'd0);
    chk("stale_rsp_no_pcwr", 64'(pc_wr), 64'd0);
    wait_req("post_rst_req", 64'h400);
    imem_req_ready = 1'b1;
    tick();
    respond(32'h0000_0033, 1'b0);
    chk("post_rst_pc",   instr_pc, 64'h400);
    chk("post_rst_data", 64'(instr_data), 64'h33);
    chk("post_rst_next", pc_wr_data, 64'h404);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
